// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory access sequencer.
//   state_e       : sequencer states
//   MEMWRITE_BIT  : index of MemWrite inside the MEM-stage control field
//   MEMREAD_BIT   : index of MemRead inside the MEM-stage control field
//   access_is_bad : flags an access that must complete with an error and no bus cycle
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned MEMWRITE_BIT = 0;
  localparam int unsigned MEMREAD_BIT  = 1;

  // Read and write together is not a real instruction; it is treated like a
  // misaligned access so the pipeline still sees a clean error completion.
  function automatic logic access_is_bad(input logic [1:0] mem_m, input logic [1:0] addr_lo);
    return (mem_m[MEMWRITE_BIT] && mem_m[MEMREAD_BIT]) || (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_wait_timer.sv
// Wait-cycle counter for a bus access.
//   i_clk   : rising-edge clock
//   i_reset : asynchronous active-high reset
//   i_load  : clear the count (start of a new access)
//   i_en    : count one wait cycle
//   o_term  : count has reached TIMEOUT-1
// The count saturates at TIMEOUT-1 instead of wrapping.
module dmem_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_term
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  logic [CntW-1:0] r_cnt;

  assign o_term = (r_cnt == CntW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en && !o_term) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer. Issues one req/ready bus cycle per
// pending load/store, stalls the pipeline until it completes, and returns
// registered load data with a done pulse (plus err on misalign/illegal/timeout).
//   i_clk, i_reset          : clock, asynchronous active-high reset
//   i_mem_m                 : MEM-stage control {MemRead, MemWrite}
//   i_mem_addr, i_mem_wdata : MEM-stage byte address and store data
//   o_stall                 : freeze upstream pipeline registers
//   o_done, o_err           : completion pulse, error qualifier
//   o_load_data             : registered read data, valid with o_done
//   o_bus_*                 : registered memory request, write enable, address, data
//   i_bus_ready, i_bus_rdata: memory completion and read data (used only in BUSY)
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [1:0]        i_mem_m,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic              o_stall,
  output logic              o_done,
  output logic [DATA_W-1:0] o_load_data,
  output logic              o_err,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic              i_bus_ready,
  input  logic [DATA_W-1:0] i_bus_rdata
);

  state_e            r_state;
  state_e            w_state_d;
  logic              r_err;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [DATA_W-1:0] r_load_data;

  logic w_pending;
  logic w_bad;
  logic w_start;
  logic w_fin_ok;
  logic w_fin_err;
  logic w_term;

  assign w_pending = (i_mem_m != 2'b00);
  assign w_bad     = access_is_bad(i_mem_m, i_mem_addr[1:0]);

  dmem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_start),
    .i_en    (r_state == BUSY),
    .o_term  (w_term)
  );

  always_comb begin
    w_state_d = r_state;
    w_start   = 1'b0;
    w_fin_ok  = 1'b0;
    w_fin_err = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pending) begin
          if (w_bad) begin
            w_state_d = DONE;
            w_fin_err = 1'b1;
          end else begin
            w_state_d = BUSY;
            w_start   = 1'b1;
          end
        end
      end
      BUSY: begin
        if (i_bus_ready) begin
          w_state_d = DONE;
          w_fin_ok  = 1'b1;
        end else if (w_term) begin
          w_state_d = DONE;
          w_fin_err = 1'b1;
        end
      end
      DONE: begin
        w_state_d = IDLE;
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
    // Low in DONE so the pipeline advances exactly at the edge that ends DONE.
    o_stall = ((r_state == IDLE) && w_pending) || (r_state == BUSY);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_err       <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_load_data <= '0;
    end else begin
      r_state <= w_state_d;
      // Set only on entry to DONE, so it clears on the way out.
      r_err   <= w_fin_err;
      if (w_start) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= i_mem_m[MEMWRITE_BIT];
        r_bus_addr  <= i_mem_addr;
        r_bus_wdata <= i_mem_wdata;
      end else if (w_fin_ok || w_fin_err) begin
        r_bus_req <= 1'b0;
      end
      if (w_fin_ok && !r_bus_we) begin
        r_load_data <= i_bus_rdata;
      end else if (w_fin_err) begin
        r_load_data <= '0;
      end
    end
  end

  assign o_done      = (r_state == DONE);
  assign o_err       = o_done && r_err;
  assign o_load_data = r_load_data;
  assign o_bus_req   = r_bus_req;
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;

endmodule
